axi_handshake_pair: RTL and testbench
=====================================

Name: axi_handshake_pair

Overview:
- Self-contained AXI-style VALID/READY handshake demonstrator: a master side sourcing an incrementing 32-bit data stream and a slave side accepting it with a programmable backpressure pattern.
- The master-to-slave channel leaves the block and re-enters it on separate ports, so a bench can insert wire delay or corruption between the two sides.
- Used as a protocol reference and a checker target for handshake timing.

Parameters:
- DATA_W, 32, data channel width.
- START_VAL, 1, first data word sent after reset; also the slave's first expected word.
- MASTER_GAP, 0, idle cycles with valid low inserted by the master after each accepted transfer.
- READY_LAT, 1, cycles after reset release before the slave first raises ready.
- READY_GAP, 2, cycles the slave holds ready low after each accepted transfer.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- m_data  out  DATA_W  master data toward the channel.
- m_valid  out  1  master valid toward the channel.
- m_ready_in  in  1  ready as seen by the master (bench loops back s_ready).
- s_data_in  in  DATA_W  data as seen by the slave (bench loops back m_data).
- s_valid_in  in  1  valid as seen by the slave (bench loops back m_valid, optionally delayed).
- s_ready  out  1  slave ready toward the channel.
- rx_data  out  DATA_W  last word accepted by the slave.
- data_success  out  1  one-cycle pulse, the cycle after each slave-side acceptance.
- xfer_count  out  16  number of accepted transfers, wraps at 2^16.
- seq_error  out  1  sticky flag: an accepted word differed from the expected sequence value.

Behaviour:
- Reset (rst high at a posedge) drives the following values:
  - m_valid=0, m_data=START_VAL.
  - s_ready=0, rx_data=0, data_success=0, xfer_count=0, seq_error=0.
  - Slave expected value reloads to START_VAL.
  - Both FSMs return to their initial states.
- Every output is a register output; there is no combinational path from any input to any output.
- Master handshake: m_valid && m_ready_in sampled at a posedge.
- Slave handshake: s_valid_in && s_ready sampled at a posedge.
- The two handshakes are evaluated independently.
- Master FSM:
  - IDLE: entered on reset. The next cycle moves to VALID with m_valid=1.
  - VALID: m_valid=1 and m_data held stable until the master handshake occurs. m_valid must never drop without a handshake.
  - On handshake: m_data <= m_data+1, modulo 2^DATA_W, so 0xFFFFFFFF wraps to 0x00000000. If MASTER_GAP=0, stay in VALID and present the new word on the next cycle. Otherwise go to GAP.
  - GAP: m_valid=0 for exactly MASTER_GAP cycles, then return to VALID.
- Slave ready generator:
  - After reset, s_ready stays 0 for READY_LAT cycles, then rises.
  - s_ready never depends on s_valid_in; the slave does not wait for valid.
  - On a slave handshake: if READY_GAP=0, s_ready stays 1. Otherwise s_ready drops for READY_GAP cycles, then returns to 1.
- On a slave handshake, in the same posedge:
  - rx_data <= s_data_in; xfer_count <= xfer_count+1.
  - data_success asserts on the following cycle, for exactly one cycle.
  - If s_data_in != expected, seq_error <= 1 (sticky until reset).
  - expected <= s_data_in+1, so the checker resynchronises after an error.
- Throughput with defaults (MASTER_GAP=0, READY_GAP=2): one transfer per 3 cycles. With READY_GAP=0 and MASTER_GAP=0: one transfer every cycle.
- Delayed channel: if s_valid_in lags m_valid, the two sides may see different handshake cycles. Each side acts only on its own view. The block itself guarantees nothing; bench loopback without delay is the normal mode.
- Reset mid-transfer: the in-flight word is discarded. The master restarts at START_VAL and no data_success pulse is issued for it.

Test Plan:
- Reset then direct loopback, defaults:
  - s_ready rises on cycle 2 after rst falls; m_valid rises on cycle 1.
  - First acceptance rx_data=0x00000001; data_success pulses 1 cycle later.
  - Subsequent words 2, 3, 4 arrive at 3-cycle spacing; seq_error=0.
- READY_GAP=0, MASTER_GAP=0: after the first handshake, m_valid and s_ready both stay high. rx_data increments every cycle and data_success stays high; 8 cycles give xfer_count=8.
- MASTER_GAP=2, READY_GAP=0: m_valid pattern is high 1 cycle, low 2 cycles. data_success pulses every 3 cycles.
- Wrap-around with START_VAL=0xFFFFFFFE: accepted words are 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; seq_error=0.
- Bench corrupts s_data_in on the 3rd transfer (XOR 0x1): seq_error=1 and stays set. The 4th transfer still completes; rx_data=4.
- Assert rst while m_valid=1 and s_ready=0:
  - Next cycle all outputs are at reset values.
  - After release, the first accepted word is START_VAL; xfer_count restarts at 1.

Source files
------------

// File: rtl/axi_handshake_pair.sv
// axi_handshake_pair: VALID/READY demonstrator with an incrementing master source
// and a slave sink with programmable ready backpressure and a sequence checker.
module axi_handshake_pair #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] START_VAL  = 1,
    parameter int                MASTER_GAP = 0,
    parameter int                READY_LAT  = 1,
    parameter int                READY_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready_in,
    input  logic [DATA_W-1:0] s_data_in,
    input  logic              s_valid_in,
    output logic              s_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              data_success,
    output logic [15:0]       xfer_count,
    output logic              seq_error
);
    typedef enum logic [1:0] {M_IDLE, M_VALID, M_GAP} m_state_t;
    m_state_t          r_m_state, w_m_next;
    logic              r_m_valid, r_s_ready, r_succ, r_err;
    logic [DATA_W-1:0] r_m_data, r_rx, r_exp;
    logic [15:0]       r_m_gap, r_s_cnt, r_xfer;
    logic              w_m_hs, w_s_hs;
    assign w_m_hs = r_m_valid && m_ready_in;
    assign w_s_hs = s_valid_in && r_s_ready;
    always_comb begin
        w_m_next = (r_m_state == M_IDLE)  ? M_VALID :
                   (r_m_state == M_VALID) ? ((w_m_hs && MASTER_GAP != 0) ? M_GAP : M_VALID) :
                   (r_m_state == M_GAP)   ? ((r_m_gap == 16'd0) ? M_VALID : M_GAP) : M_IDLE;
    end
    // gap counter is preloaded every VALID cycle so it is ready on entry to GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_state <= M_IDLE;
            r_m_valid <= 1'b0;
            r_m_data  <= START_VAL;
            r_m_gap   <= 16'd0;
        end else begin
            r_m_state <= w_m_next;
            r_m_valid <= (w_m_next == M_VALID);
            r_m_gap   <= (r_m_state == M_VALID) ? 16'(MASTER_GAP - 1) :
                         r_m_gap - 16'(r_m_gap != 16'd0);
            if (w_m_hs)
                r_m_data <= r_m_data + DATA_W'(1);
        end
    end
    // ready is independent of valid; the reset cycle itself is not counted in the latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_ready <= 1'b0;
            r_s_cnt   <= 16'(READY_LAT);
            r_rx      <= '0;
            r_succ    <= 1'b0;
            r_xfer    <= 16'd0;
            r_err     <= 1'b0;
            r_exp     <= START_VAL;
        end else begin
            r_succ <= w_s_hs;
            if (w_s_hs) begin
                r_s_ready <= (READY_GAP == 0);
                r_s_cnt   <= 16'(READY_GAP - 1);
                r_rx      <= s_data_in;
                r_xfer    <= r_xfer + 16'd1;
                r_err     <= r_err || (s_data_in != r_exp);
                r_exp     <= s_data_in + DATA_W'(1);
            end else if (!r_s_ready) begin
                r_s_ready <= (r_s_cnt == 16'd0);
                r_s_cnt   <= r_s_cnt - 16'(r_s_cnt != 16'd0);
            end
        end
    end
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign s_ready      = r_s_ready;
    assign rx_data      = r_rx;
    assign data_success = r_succ;
    assign xfer_count   = r_xfer;
    assign seq_error    = r_err;
endmodule

// File: tb/tb_axi_handshake_pair.sv
// tb_axi_handshake_pair: four loopback instances (defaults, full rate, master gap, wrap)
// checked by directed steps plus a per-instance scoreboard of accepted words.
module tb_axi_handshake_pair;
    localparam logic [31:0] START [4] = '{32'd1, 32'd1, 32'd1, 32'hFFFFFFFE};
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] c0 = 32'd0;
    logic [31:0] md [4];
    logic [31:0] sd [4];
    logic [31:0] rx [4];
    logic [15:0] xc [4];
    logic        mv [4];
    logic        sr [4];
    logic        ds [4];
    logic        se [4];
    logic [31:0] q [4][$];
    logic [31:0] exp_m [4];
    logic [15:0] cnt_m [4];
    logic        err_m [4];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    always #5 clk = ~clk;
    assign sd[0] = md[0] ^ c0;
    assign sd[1] = md[1];
    assign sd[2] = md[2];
    assign sd[3] = md[3];
    axi_handshake_pair u0 (
        .clk(clk), .rst(rst), .m_data(md[0]), .m_valid(mv[0]), .m_ready_in(sr[0]),
        .s_data_in(sd[0]), .s_valid_in(mv[0]), .s_ready(sr[0]), .rx_data(rx[0]),
        .data_success(ds[0]), .xfer_count(xc[0]), .seq_error(se[0]));
    axi_handshake_pair #(.READY_GAP(0)) u1 (
        .clk(clk), .rst(rst), .m_data(md[1]), .m_valid(mv[1]), .m_ready_in(sr[1]),
        .s_data_in(sd[1]), .s_valid_in(mv[1]), .s_ready(sr[1]), .rx_data(rx[1]),
        .data_success(ds[1]), .xfer_count(xc[1]), .seq_error(se[1]));
    axi_handshake_pair #(.MASTER_GAP(2), .READY_GAP(0)) u2 (
        .clk(clk), .rst(rst), .m_data(md[2]), .m_valid(mv[2]), .m_ready_in(sr[2]),
        .s_data_in(sd[2]), .s_valid_in(mv[2]), .s_ready(sr[2]), .rx_data(rx[2]),
        .data_success(ds[2]), .xfer_count(xc[2]), .seq_error(se[2]));
    axi_handshake_pair #(.START_VAL(32'hFFFFFFFE)) u3 (
        .clk(clk), .rst(rst), .m_data(md[3]), .m_valid(mv[3]), .m_ready_in(sr[3]),
        .s_data_in(sd[3]), .s_valid_in(mv[3]), .s_ready(sr[3]), .rx_data(rx[3]),
        .data_success(ds[3]), .xfer_count(xc[3]), .seq_error(se[3]));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask
    task automatic chk_reset();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_rst_mdata", i), md[i], START[i]);
            chk($sformatf("u%0d_rst_mvalid", i), 32'(mv[i]), 32'd0);
            chk($sformatf("u%0d_rst_sready", i), 32'(sr[i]), 32'd0);
            chk($sformatf("u%0d_rst_rx", i), rx[i], 32'd0);
            chk($sformatf("u%0d_rst_succ", i), 32'(ds[i]), 32'd0);
            chk($sformatf("u%0d_rst_cnt", i), 32'(xc[i]), 32'd0);
            chk($sformatf("u%0d_rst_err", i), 32'(se[i]), 32'd0);
        end
    endtask
    // capture handshakes before the edge, then score the DUT after it
    task automatic tick();
        logic        h [4];
        logic [31:0] w [4];
        logic [31:0] e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            h[i] = mv[i] && sr[i] && !rst;
            w[i] = sd[i];
        end
        @(posedge clk);
        #1;
        cyc = rst ? 0 : cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                q[i].delete();
                exp_m[i] = START[i];
                cnt_m[i] = 16'd0;
                err_m[i] = 1'b0;
            end else begin
                if (h[i]) begin
                    q[i].push_back(w[i]);
                    err_m[i] = err_m[i] || (w[i] != exp_m[i]);
                    exp_m[i] = w[i] + 32'd1;
                    cnt_m[i] = cnt_m[i] + 16'd1;
                end
                if (ds[i]) begin
                    e = (q[i].size() > 0) ? q[i].pop_front() : 32'hDEADBEEF;
                    chk($sformatf("u%0d_sb_rx", i), rx[i], e);
                    chk($sformatf("u%0d_sb_cnt", i), 32'(xc[i]), 32'(cnt_m[i]));
                    chk($sformatf("u%0d_sb_err", i), 32'(se[i]), 32'(err_m[i]));
                end
            end
        end
        if (cyc == 10)
            chk("u1_cnt8", 32'(xc[1]), 32'd8);
    endtask
    initial begin
        repeat (2) tick();
        chk_reset();
        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                chk("midrst_mvalid", 32'(mv[0]), 32'd1);
                chk("midrst_sready", 32'(sr[0]), 32'd0);
                rst = 1'b1;
                tick();
                chk_reset();
                rst = 1'b0;
            end
            for (int n = 1; n <= 4; n++) begin
                tick();
                chk("u0_succ_lo1", 32'(ds[0]), 32'd0);
                if (n == 1) begin
                    chk("u0_mvalid_c1", 32'(mv[0]), 32'd1);
                    chk("u0_sready_c1", 32'(sr[0]), 32'd0);
                end else
                    chk("u2_mvalid_gap1", 32'(mv[2]), 32'd0);
                tick();
                chk("u0_succ_lo2", 32'(ds[0]), 32'd0);
                chk("u2_mvalid_back", 32'(mv[2]), 32'd1);
                if (n == 1)
                    chk("u0_sready_c2", 32'(sr[0]), 32'd1);
                if (p == 1 && n == 3)
                    c0 = 32'd1;
                tick();
                c0 = 32'd0;
                chk("u0_succ_hi", 32'(ds[0]), 32'd1);
                chk("u0_rx", rx[0], (p == 1 && n == 3) ? 32'd2 : 32'(n));
                chk("u0_cnt", 32'(xc[0]), 32'(n));
                chk("u0_err", 32'(se[0]), 32'(p == 1 && n >= 3));
                chk("u0_mvalid_held", 32'(mv[0]), 32'd1);
                chk("u2_succ", 32'(ds[2]), 32'd1);
                chk("u2_rx", rx[2], 32'(n));
                chk("u3_rx_wrap", rx[3], 32'hFFFFFFFE + 32'(n - 1));
            end
            chk("u1_mvalid", 32'(mv[1]), 32'd1);
            chk("u1_sready", 32'(sr[1]), 32'd1);
            chk("u1_succ", 32'(ds[1]), 32'd1);
            chk("u1_rx", rx[1], 32'd10);
            chk("u1_cnt", 32'(xc[1]), 32'd10);
            chk("u3_err", 32'(se[3]), 32'd0);
            chk("u2_sready", 32'(sr[2]), 32'd1);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("u%0d_sb_drain", i), 32'(q[i].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
